// File: rtl/dcache_sched_pkg.sv
// -----------------------------------------------------------------------------
// dcache_sched_pkg
// Shared definitions for the data-cache port scheduler:
//   - width constants (address, data, tag, cache index)
//   - req_t: one buffered load/store request
//   - iss_mode_t: how the buffered slots drive the cache in a given cycle
//   - idx_eq: cache-index collision compare
// -----------------------------------------------------------------------------
package dcache_sched_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 4;
    localparam int IDX_W  = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef enum logic [2:0] {
        ISS_NONE,
        ISS_LD,
        ISS_ST,
        ISS_SPLIT,
        ISS_FWD
    } iss_mode_t;

    // Two requests touch the same cache word when their index bits agree.
    function automatic logic idx_eq(input logic [IDX_W-1:0] a, input logic [IDX_W-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/dcache_sched_if.sv
// -----------------------------------------------------------------------------
// dcache_sched_if
// Bundles the two issue-lane request/response channels and the dual-port
// cache bus of the scheduler.
//   slave  : scheduler side (takes requests and cache read data, drives
//            ready, cache address/data/write enable and responses)
//   master : lane + cache side (drives requests and cache read data)
// Signals:
//   reqN_valid/ready/we/addr/wdata/tag    lane N request, N = 0,1
//   mem_write, mem_access_addrN,
//   mem_write_dataN, mem_read_dataN       cache ports 0/1
//   rspN_valid/we/tag/data                lane N response (no backpressure)
// -----------------------------------------------------------------------------
interface dcache_sched_if;
    import dcache_sched_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic [TAG_W-1:0]  req1_tag;

    logic              mem_write;
    logic [ADDR_W-1:0] mem_access_addr0;
    logic [ADDR_W-1:0] mem_access_addr1;
    logic [DATA_W-1:0] mem_write_data0;
    logic [DATA_W-1:0] mem_write_data1;
    logic [DATA_W-1:0] mem_read_data0;
    logic [DATA_W-1:0] mem_read_data1;

    logic              rsp0_valid;
    logic              rsp0_we;
    logic [TAG_W-1:0]  rsp0_tag;
    logic [DATA_W-1:0] rsp0_data;

    logic              rsp1_valid;
    logic              rsp1_we;
    logic [TAG_W-1:0]  rsp1_tag;
    logic [DATA_W-1:0] rsp1_data;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_tag,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_tag,
        input  mem_read_data0, mem_read_data1,
        output req0_ready, req1_ready,
        output mem_write, mem_access_addr0, mem_access_addr1,
        output mem_write_data0, mem_write_data1,
        output rsp0_valid, rsp0_we, rsp0_tag, rsp0_data,
        output rsp1_valid, rsp1_we, rsp1_tag, rsp1_data
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_tag,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_tag,
        output mem_read_data0, mem_read_data1,
        input  req0_ready, req1_ready,
        input  mem_write, mem_access_addr0, mem_access_addr1,
        input  mem_write_data0, mem_write_data1,
        input  rsp0_valid, rsp0_we, rsp0_tag, rsp0_data,
        input  rsp1_valid, rsp1_we, rsp1_tag, rsp1_data
    );

endinterface

// File: rtl/dcache_sched_slot.sv
// -----------------------------------------------------------------------------
// dcache_sched_slot
// One-entry request holding register.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears valid only)
//   load        capture d; wins over clear so an issuing slot can refill
//   clear       drop the held request (it issued this cycle)
//   d           incoming request
//   valid, q    slot occupancy and held request
// -----------------------------------------------------------------------------
module dcache_sched_slot
    import dcache_sched_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  req_t d,
    output logic valid,
    output req_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    // Payload is only observed while valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dcache_sched.sv
// -----------------------------------------------------------------------------
// dcache_sched
// Schedules two load/store issue lanes onto a dual-port 256x16 data cache
// whose single write enable writes both ports. Each lane owns a one-entry
// slot; every cycle the slots are decoded into an issue mode:
//   NONE  nothing pending
//   LD    only loads: slot N on port N (a lone load is mirrored)
//   ST    only stores: younger store on port 1 so it wins an index collision
//   SPLIT load + store: the older slot issues alone, the younger waits
//   FWD   older store + younger load to the same index issue together, the
//         load returns the store data (only with DCACHE_SCHED_FWD_EN defined)
// Responses are registered one edge after issue.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    dcache_sched_if.slave: lane requests/responses and cache bus
// Build option: define DCACHE_SCHED_FWD_EN to enable the FWD issue mode.
// -----------------------------------------------------------------------------
module dcache_sched
    import dcache_sched_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    dcache_sched_if.slave bus
);

    req_t      d0, d1, s0, s1;
    logic      v0, v1;
    logic      ld0, ld1;
    logic      iss0, iss1;
    logic      rdy0, rdy1;
    logic      older;          // 1: S1 is the older slot, 0: S0 is older
    iss_mode_t mode;

    logic              old_we;
    logic [ADDR_W-1:0] old_addr, young_addr, lone_addr;
    logic [DATA_W-1:0] old_wdata, young_wdata, lone_wdata;

    logic              mem_we;
    logic [ADDR_W-1:0] port_addr0, port_addr1;
    logic [DATA_W-1:0] port_wdata0, port_wdata1;
    logic [DATA_W-1:0] rdat0, rdat1;

    logic [1:0]        vld_p1;
    logic [1:0]        we_p1;
    logic [TAG_W-1:0]  tag0_p1, tag1_p1;
    logic [DATA_W-1:0] data0_p1, data1_p1;

    assign d0 = '{we: bus.req0_we, addr: bus.req0_addr, wdata: bus.req0_wdata, tag: bus.req0_tag};
    assign d1 = '{we: bus.req1_we, addr: bus.req1_addr, wdata: bus.req1_wdata, tag: bus.req1_tag};

    // Ready is a function of slot state only, never of req*_valid.
    assign rdy0 = !v0 || iss0;
    assign rdy1 = !v1 || iss1;
    assign ld0  = bus.req0_valid && rdy0;
    assign ld1  = bus.req1_valid && rdy1;

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;

    dcache_sched_slot u_slot0 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld0),
        .clear (iss0),
        .d     (d0),
        .valid (v0),
        .q     (s0)
    );

    dcache_sched_slot u_slot1 (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (ld1),
        .clear (iss1),
        .d     (d1),
        .valid (v1),
        .q     (s1)
    );

    // A slot loading alone becomes the younger one: if the other slot holds
    // it is older; if the other slot is empty the bit is rewritten when it
    // next loads. Both loading together makes S0 older.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older <= 1'b0;
        end else if (ld0 || ld1) begin
            older <= ld0 && !ld1;
        end
    end

    assign old_we      = older ? s1.we    : s0.we;
    assign old_addr    = older ? s1.addr  : s0.addr;
    assign old_wdata   = older ? s1.wdata : s0.wdata;
    assign young_addr  = older ? s0.addr  : s1.addr;
    assign young_wdata = older ? s0.wdata : s1.wdata;
    assign lone_addr   = v0 ? s0.addr  : s1.addr;
    assign lone_wdata  = v0 ? s0.wdata : s1.wdata;

    always_comb begin
        mode = ISS_NONE;
        if (v0 && v1) begin
            if (s0.we == s1.we) begin
                mode = s0.we ? ISS_ST : ISS_LD;
            end else begin
                mode = ISS_SPLIT;
`ifdef DCACHE_SCHED_FWD_EN
                // Mixed pair: an older store means the younger is the load.
                if (old_we && idx_eq(s0.addr[IDX_W-1:0], s1.addr[IDX_W-1:0])) begin
                    mode = ISS_FWD;
                end
`endif
            end
        end else if (v0 || v1) begin
            mode = (v0 ? s0.we : s1.we) ? ISS_ST : ISS_LD;
        end
    end

    always_comb begin
        iss0        = 1'b0;
        iss1        = 1'b0;
        mem_we      = 1'b0;
        port_addr0  = '0;
        port_addr1  = '0;
        port_wdata0 = '0;
        port_wdata1 = '0;
        case (mode)
            ISS_LD: begin
                iss0       = v0;
                iss1       = v1;
                port_addr0 = v0 ? s0.addr : s1.addr;
                port_addr1 = v1 ? s1.addr : s0.addr;
            end
            ISS_ST: begin
                iss0   = v0;
                iss1   = v1;
                mem_we = 1'b1;
                if (v0 && v1) begin
                    port_addr0  = old_addr;
                    port_wdata0 = old_wdata;
                    port_addr1  = young_addr;
                    port_wdata1 = young_wdata;
                end else begin
                    port_addr0  = lone_addr;
                    port_wdata0 = lone_wdata;
                    port_addr1  = lone_addr;
                    port_wdata1 = lone_wdata;
                end
            end
            ISS_SPLIT: begin
                iss0       = !older;
                iss1       = older;
                mem_we     = old_we;
                port_addr0 = old_addr;
                port_addr1 = old_addr;
                if (old_we) begin
                    port_wdata0 = old_wdata;
                    port_wdata1 = old_wdata;
                end
            end
            ISS_FWD: begin
                iss0        = 1'b1;
                iss1        = 1'b1;
                mem_we      = 1'b1;
                port_addr0  = old_addr;
                port_addr1  = old_addr;
                port_wdata0 = old_wdata;
                port_wdata1 = old_wdata;
            end
            default: begin
            end
        endcase
    end

    assign bus.mem_write        = mem_we;
    assign bus.mem_access_addr0 = port_addr0;
    assign bus.mem_access_addr1 = port_addr1;
    assign bus.mem_write_data0  = port_wdata0;
    assign bus.mem_write_data1  = port_wdata1;

    // Slot N always reads through port N (mirroring makes this hold for a
    // lone load too); in FWD the load takes the store's data instead.
    assign rdat0 = s0.we ? s0.wdata : ((mode == ISS_FWD) ? old_wdata : bus.mem_read_data0);
    assign rdat1 = s1.we ? s1.wdata : ((mode == ISS_FWD) ? old_wdata : bus.mem_read_data1);

    // ---- stage p1: responses registered at the issue edge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= '0;
            we_p1    <= '0;
            tag0_p1  <= '0;
            tag1_p1  <= '0;
            data0_p1 <= '0;
            data1_p1 <= '0;
        end else begin
            vld_p1 <= {iss1, iss0};
            if (iss0) begin
                we_p1[0] <= s0.we;
                tag0_p1  <= s0.tag;
                data0_p1 <= rdat0;
            end
            if (iss1) begin
                we_p1[1] <= s1.we;
                tag1_p1  <= s1.tag;
                data1_p1 <= rdat1;
            end
        end
    end

    assign bus.rsp0_valid = vld_p1[0];
    assign bus.rsp0_we    = we_p1[0];
    assign bus.rsp0_tag   = tag0_p1;
    assign bus.rsp0_data  = data0_p1;
    assign bus.rsp1_valid = vld_p1[1];
    assign bus.rsp1_we    = we_p1[1];
    assign bus.rsp1_tag   = tag1_p1;
    assign bus.rsp1_data  = data1_p1;

endmodule

// File: tb/tb_dcache_sched.sv
// -----------------------------------------------------------------------------
// tb_dcache_sched
// Directed bench for dcache_sched with a 256x16 cache model (word i = i).
// Expected responses are queued per lane when a request is accepted and are
// popped by a monitor whenever a response is presented. Port-level checks
// (write enable, mirrored ports, ready) are made directly in the stimulus.
// Honours DCACHE_SCHED_FWD_EN for the store->load forwarding case.
// -----------------------------------------------------------------------------
module tb_dcache_sched;
    import dcache_sched_pkg::*;

    typedef struct packed {
        logic              we;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

`ifdef DCACHE_SCHED_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_sched_if bus ();

    dcache_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DATA_W-1:0] mem [256];
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   errors = 0;
    int   checks = 0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= DATA_W'(i);
    end

    // Both ports are written on a write cycle; port 1 lands last.
    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[bus.mem_access_addr0[IDX_W-1:0]] <= bus.mem_write_data0;
            mem[bus.mem_access_addr1[IDX_W-1:0]] <= bus.mem_write_data1;
        end
    end

    assign bus.mem_read_data0 = mem[bus.mem_access_addr0[IDX_W-1:0]];
    assign bus.mem_read_data1 = mem[bus.mem_access_addr1[IDX_W-1:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic req_t mk(input logic we, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] wd, input logic [TAG_W-1:0] t);
        req_t r;
        r.we    = we;
        r.addr  = a;
        r.wdata = wd;
        r.tag   = t;
        return r;
    endfunction

    // Monitor: sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rsp0_valid) begin
                chk("rsp0_expected_pending", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    chk("rsp0_we_tag_data", 32'({bus.rsp0_we, bus.rsp0_tag, bus.rsp0_data}), 32'(e0));
                end
            end
            if (bus.rsp1_valid) begin
                chk("rsp1_expected_pending", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("rsp1_we_tag_data", 32'({bus.rsp1_we, bus.rsp1_tag, bus.rsp1_data}), 32'(e1));
                end
            end
        end
    end

    // Called at posedge+1. Holds each request until accepted and queues the
    // expected response (x0/x1 = expected data) when track is set.
    // Returns at posedge+1 after the last acceptance edge.
    task automatic send(input bit v0, input req_t r0, input logic [DATA_W-1:0] x0,
                        input bit v1, input req_t r1, input logic [DATA_W-1:0] x1,
                        input bit track);
        bit   p0 = v0;
        bit   p1 = v1;
        bit   a0, a1;
        int   n = 0;
        exp_t x;
        bus.req0_we    = r0.we;
        bus.req0_addr  = r0.addr;
        bus.req0_wdata = r0.wdata;
        bus.req0_tag   = r0.tag;
        bus.req1_we    = r1.we;
        bus.req1_addr  = r1.addr;
        bus.req1_wdata = r1.wdata;
        bus.req1_tag   = r1.tag;
        bus.req0_valid = p0;
        bus.req1_valid = p1;
        while ((p0 || p1) && n < 20) begin
            a0 = p0 && bus.req0_ready;
            a1 = p1 && bus.req1_ready;
            @(posedge clk);
            #1;
            if (a0) begin
                if (track) begin
                    x = '{we: r0.we, tag: r0.tag, data: x0};
                    q0.push_back(x);
                end
                p0 = 1'b0;
            end
            if (a1) begin
                if (track) begin
                    x = '{we: r1.we, tag: r1.tag, data: x1};
                    q1.push_back(x);
                end
                p1 = 1'b0;
            end
            bus.req0_valid = p0;
            bus.req1_valid = p1;
            n++;
        end
        chk("handshake_timeout", 32'(p0 || p1), 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_we    = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_wdata = '0;
        bus.req0_tag   = '0;
        bus.req1_valid = 1'b0;
        bus.req1_we    = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_wdata = '0;
        bus.req1_tag   = '0;

        // Reset state
        #12;
        chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        chk("rst_rsp0_data_tag_we", {bus.rsp0_we, bus.rsp0_tag, bus.rsp0_data}, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_mem_addr", {bus.mem_access_addr0, bus.mem_access_addr1}, 0);
        chk("rst_mem_wdata", {bus.mem_write_data0, bus.mem_write_data1}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b11);

        // Paired loads: both responses two edges after acceptance
        send(1, mk(0, 16'h0010, 16'h0000, 4'h1), 16'h0010,
             1, mk(0, 16'h0020, 16'h0000, 4'h2), 16'h0020, 1);
        chk("ld_pair_ports", {bus.mem_access_addr0, bus.mem_access_addr1}, {16'h0010, 16'h0020});
        @(posedge clk);
        #1;
        chk("ld_pair_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 2'b11);
        idle(2);

        // Paired stores to one index: younger (lane1) on port 1, one write cycle
        send(1, mk(1, 16'h0005, 16'hAAAA, 4'h3), 16'hAAAA,
             1, mk(1, 16'h0105, 16'hBBBB, 4'h4), 16'hBBBB, 1);
        chk("st_pair_mem_write", bus.mem_write, 1);
        chk("st_pair_port0", {bus.mem_access_addr0, bus.mem_write_data0}, {16'h0005, 16'hAAAA});
        chk("st_pair_port1", {bus.mem_access_addr1, bus.mem_write_data1}, {16'h0105, 16'hBBBB});
        @(posedge clk);
        #1;
        chk("st_pair_single_write", bus.mem_write, 0);
        chk("st_collision_word", mem[5], 16'hBBBB);
        send(1, mk(0, 16'h0005, 16'h0000, 4'h5), 16'hBBBB, 0, '0, '0, 1);
        idle(2);

        // Lone store mirrored to both ports
        send(0, '0, '0, 1, mk(1, 16'h0030, 16'h1234, 4'h6), 16'h1234, 1);
        chk("lone_st_mem_write", bus.mem_write, 1);
        chk("lone_st_addr", {bus.mem_access_addr0, bus.mem_access_addr1}, {16'h0030, 16'h0030});
        chk("lone_st_wdata", {bus.mem_write_data0, bus.mem_write_data1}, {16'h1234, 16'h1234});
        idle(2);

        // Older store + younger load to the same index
        send(1, mk(1, 16'h0040, 16'h5555, 4'h7), 16'h5555,
             1, mk(0, 16'h0040, 16'h0000, 4'h8), 16'h5555, 1);
        chk("stld_mem_write", bus.mem_write, 1);
        chk("stld_req1_ready", bus.req1_ready, FWD);
        @(posedge clk);
        #1;
        chk("stld_rsp0_valid", bus.rsp0_valid, 1);
        chk("stld_rsp1_same_cycle", bus.rsp1_valid, FWD);
        chk("stld_req1_ready_next", bus.req1_ready, 1);
        idle(3);

        // Older load + younger store to the same index: load goes first
        send(1, mk(0, 16'h0050, 16'h0000, 4'h9), 16'h0050,
             1, mk(1, 16'h0050, 16'h7777, 4'hA), 16'h7777, 1);
        chk("ldst_load_first", {bus.mem_write, bus.mem_access_addr0}, {1'b0, 16'h0050});
        @(posedge clk);
        #1;
        chk("ldst_store_second", bus.mem_write, 1);
        send(0, '0, '0, 1, mk(0, 16'h0050, 16'h0000, 4'hB), 16'h7777, 1);
        idle(3);

        // Age after refill: lane1 load holds while lane0 refills with a store
        // to the same index; the held load is older and must read the old word.
        send(1, mk(1, 16'h0060, 16'h1111, 4'hC), 16'h1111,
             1, mk(0, 16'h0061, 16'h0000, 4'hD), 16'h0061, 1);
        send(1, mk(1, 16'h0061, 16'h2222, 4'hE), 16'h2222, 0, '0, '0, 1);
        chk("age_load_first", bus.mem_write, 0);
        @(posedge clk);
        #1;
        chk("age_store_second", {bus.mem_write, bus.mem_write_data0}, {1'b1, 16'h2222});
        send(1, mk(0, 16'h0061, 16'h0000, 4'hF), 16'h2222, 0, '0, '0, 1);
        idle(4);

        // Reset while both slots hold stores: nothing may be written
        send(1, mk(1, 16'h0070, 16'hCAFE, 4'h1), 16'h0000,
             1, mk(1, 16'h0071, 16'hBEEF, 4'h2), 16'h0000, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_write", bus.mem_write, 0);
        chk("rst_mid_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
        @(posedge clk);
        #1;
        chk("rst_mid_word70", mem[8'h70], 16'h0070);
        chk("rst_mid_word71", mem[8'h71], 16'h0071);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", {bus.req0_ready, bus.req1_ready}, 2'b11);
        @(posedge clk);
        #1;
        send(1, mk(0, 16'h0070, 16'h0000, 4'h3), 16'h0070,
             1, mk(0, 16'h0071, 16'h0000, 4'h4), 16'h0071, 1);
        idle(4);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
